// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding and width helpers for the banked data memory.
package dmem_pkg;

    typedef enum logic {CLEAR, RUN} state_t;

    function automatic int sel_w(input int num_banks);
        return $clog2(num_banks);
    endfunction

    function automatic int addr_w(input int num_banks, input int bank_addr_w);
        return bank_addr_w + $clog2(num_banks);
    endfunction

    function automatic int lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: one storage bank with byte-enabled synchronous write and registered read.
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int BANK_ADDR_W = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       we,
    input  logic [lanes(DATA_W)-1:0]   be,
    input  logic [BANK_ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata
);

    logic [DATA_W-1:0] mem [2**BANK_ADDR_W];

    always_ff @(posedge clk) begin
        if (en && we)
            for (int i = 0; i < lanes(DATA_W); i++)
                if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end

    // rdata only moves on a read, so the top-level mux output holds between responses
    always_ff @(posedge clk) begin
        if (reset) rdata <= '0;
        else if (en && !we) rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_banked.sv
// dmem_banked: banked single-port data memory with request handshake, byte enables,
// selectable interleave and a post-reset clearing sweep.
module dmem_banked
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_BANKS   = 8,
    parameter int BANK_ADDR_W = 10,
    parameter int INTERLEAVE  = 0
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    req_valid,
    output logic                                    req_ready,
    input  logic                                    req_write,
    input  logic [addr_w(NUM_BANKS,BANK_ADDR_W)-1:0] req_addr,
    input  logic [lanes(DATA_W)-1:0]                req_be,
    input  logic [DATA_W-1:0]                       req_wdata,
    output logic                                    rsp_valid,
    output logic [DATA_W-1:0]                       rsp_data,
    output logic                                    init_done
);

    localparam int SW = sel_w(NUM_BANKS);
    localparam int AW = addr_w(NUM_BANKS, BANK_ADDR_W);

    state_t                   state, state_d;
    logic [BANK_ADDR_W-1:0]   cnt;
    logic [SW-1:0]            bank, sel_q;
    logic [BANK_ADDR_W-1:0]   idx;
    logic                     clearing, last, accept;
    logic                     bank_we;
    logic [lanes(DATA_W)-1:0] bank_be;
    logic [BANK_ADDR_W-1:0]   bank_addr;
    logic [DATA_W-1:0]        bank_wdata;
    logic [DATA_W-1:0]        rdata [NUM_BANKS];

    assign bank = (INTERLEAVE != 0) ? req_addr[SW-1:0] : req_addr[AW-1:BANK_ADDR_W];
    assign idx  = (INTERLEAVE != 0) ? req_addr[AW-1:SW] : req_addr[BANK_ADDR_W-1:0];

    assign clearing = state == CLEAR;
    assign last     = cnt == '1;
    assign accept   = req_valid && req_ready && !reset;

    always_comb begin
        state_d   = (clearing && last) ? RUN : state;
        req_ready = state == RUN;
        init_done = state == RUN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            sel_q     <= '0;
        end else begin
            state     <= state_d;
            cnt       <= clearing ? cnt + 1'b1 : cnt;
            rsp_valid <= accept && !req_write;
            if (accept && !req_write) sel_q <= bank;
        end
    end

    // the clear sweep drives the same index into every bank at once
    assign bank_we    = clearing || req_write;
    assign bank_be    = clearing ? '1 : req_be;
    assign bank_addr  = clearing ? cnt : idx;
    assign bank_wdata = clearing ? '0 : req_wdata;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        dmem_bank #(.DATA_W(DATA_W), .BANK_ADDR_W(BANK_ADDR_W)) u_bank (
            .clk   (clk),
            .reset (reset),
            .en    (clearing || (accept && bank == SW'(b))),
            .we    (bank_we),
            .be    (bank_be),
            .addr  (bank_addr),
            .wdata (bank_wdata),
            .rdata (rdata[b])
        );
    end

    assign rsp_data = rdata[sel_q];

endmodule

// File: tb/tb_dmem_banked.sv
// tb_dmem_banked: scoreboard bench driving a contiguous and an interleaved instance in lockstep.
module tb_dmem_banked;

    logic        clk = 0, reset = 1;
    logic        req_valid = 0, req_write = 0;
    logic [12:0] req_addr = 0;
    logic [3:0]  req_be = 0;
    logic [31:0] req_wdata = 0;
    logic        ready0, rv0, done0, ready1, rv1, done1;
    logic [31:0] rd0, rd1;

    int          errors = 0, checks = 0, n_rsp = 0, n;
    logic [31:0] model [8192];
    logic [31:0] exp_q [$];
    logic [31:0] e;

    always #5 clk = ~clk;

    dmem_banked #(.INTERLEAVE(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready0), .req_write(req_write),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rv0), .rsp_data(rd0), .init_done(done0)
    );

    dmem_banked #(.INTERLEAVE(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready1), .req_write(req_write),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rv1), .rsp_data(rd1), .init_done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // called at a falling edge; the request is sampled at the next rising edge
    task automatic req(input logic w, input logic [12:0] a, input logic [3:0] be, input logic [31:0] d);
        req_valid = 1; req_write = w; req_addr = a; req_be = be; req_wdata = d;
        if (ready0 && !reset) begin
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) model[a][i*8 +: 8] = d[i*8 +: 8];
            end else exp_q.push_back(model[a]);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        req_valid = 0;
        @(negedge clk);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8192; i++) model[i] = '0;
    endtask

    always @(negedge clk) begin
        if (rv0 || rv1) begin
            n_rsp++;
            chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rsp_data_il0", rd0, e);
                chk("rsp_data_il1", rd1, e);
                chk("rsp_valid_both", 32'({rv0, rv1}), 32'd3);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        clear_model();
        repeat (3) @(negedge clk);
        chk("reset_ready",     32'(ready0), 0);
        chk("reset_rsp_valid", 32'(rv0), 0);
        chk("reset_rsp_data",  rd0, 0);
        chk("reset_init_done", 32'(done0 | done1), 0);

        reset = 0;
        n = 0;
        while (!ready0 && n < 5000) begin n++; @(negedge clk); end
        chk("clear_cycles", 32'(n), 32'd1024);
        chk("init_done", 32'({done0, done1, ready1}), 32'd7);

        req(0, 13'h1FFF, 4'h0, 0);
        idle();
        chk("read_top_zero", rd0, 32'h0);

        req(1, 13'h0405, 4'hF, 32'hDEADBEEF);
        req(1, 13'h0405, 4'h1, 32'h000000AA);
        req(0, 13'h0405, 4'h0, 0);
        idle();
        chk("byte_merge", rd0, 32'hDEADBEAA);

        req(1, 13'h0000, 4'hF, 32'h11111111);
        req(1, 13'h0400, 4'hF, 32'h22222222);
        req(1, 13'h0001, 4'hF, 32'h33333333);
        idle();
        chk("il0_bank0_idx0",   dut0.g_bank[0].u_bank.mem[0],   32'h11111111);
        chk("il0_bank1_idx0",   dut0.g_bank[1].u_bank.mem[0],   32'h22222222);
        chk("il0_bank0_idx1",   dut0.g_bank[0].u_bank.mem[1],   32'h33333333);
        chk("il1_bank0_idx0",   dut1.g_bank[0].u_bank.mem[0],   32'h11111111);
        chk("il1_bank1_idx0",   dut1.g_bank[1].u_bank.mem[0],   32'h33333333);
        chk("il1_bank0_idx128", dut1.g_bank[0].u_bank.mem[128], 32'h22222222);
        req(0, 13'h0000, 4'h0, 0);
        req(0, 13'h0400, 4'h0, 0);
        req(0, 13'h0001, 4'h0, 0);
        idle();

        for (int i = 0; i < 8; i++) req(1, 13'(13'h0010 + i), 4'hF, $urandom);
        base = n_rsp;
        for (int i = 0; i < 8; i++) req(0, 13'(13'h0010 + i), 4'h0, 0);
        idle();
        chk("burst_rsp_count", 32'(n_rsp - base), 32'd8);

        req(1, 13'h0123, 4'hF, 32'hCAFEF00D);
        req(0, 13'h0123, 4'h0, 0);
        idle();
        chk("write_then_read", rd0, 32'hCAFEF00D);
        req(1, 13'h0123, 4'h0, 32'hFFFFFFFF);
        req(0, 13'h0123, 4'h0, 0);
        idle();
        chk("be_zero_noop", rd0, 32'hCAFEF00D);

        req(1, 13'h0200, 4'hF, 32'h55AA55AA);
        req(0, 13'h0200, 4'h0, 0);
        reset = 1;
        clear_model();
        req(0, 13'h0200, 4'h0, 0);
        chk("reset_drops_rsp", 32'({rv0, rv1}), 0);
        chk("reset_rsp_data_zero", rd0, 0);
        chk("reset_ready_low", 32'({ready0, ready1, done0}), 0);

        reset = 0;
        n = 0;
        while (!ready0 && n < 5000) begin
            if (n == 1010) begin
                req_valid = 1; req_write = 1; req_addr = 13'h0000; req_be = 4'hF; req_wdata = 32'hBADBAD00;
            end else req_valid = 0;
            n++;
            @(negedge clk);
        end
        req_valid = 0;
        chk("reclear_cycles", 32'(n), 32'd1024);

        req(0, 13'h0405, 4'h0, 0);
        req(0, 13'h0200, 4'h0, 0);
        req(0, 13'h0123, 4'h0, 0);
        req(0, 13'h0000, 4'h0, 0);
        idle();
        chk("ignored_during_clear", rd0, 32'h0);
        idle();
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_banked.md
# dmem_banked

Parameterised, banked single-port data memory for the CPU datapath: a word address is split into a bank select and a bank index, with one bank enabled per access. It adds a request/response handshake, per-byte write enables, a selectable bank-interleave mode, and a post-reset clearing sequencer that zeroes every word before accepting traffic. It sits between the load/store unit and the bank storage and replaces the fixed 8-chip data memory top level.

## Interface
- DATA_W, 32: word width in bits; multiple of 8.
- NUM_BANKS, 8: bank count; power of two, ≥2.
- BANK_ADDR_W, 10: index width per bank; bank depth = 2^BANK_ADDR_W words.
- INTERLEAVE, 0: 0 = bank select is the address MSBs (contiguous banks); 1 = bank select is the address LSBs (word-interleaved).
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  BANK_ADDR_W+log2(NUM_BANKS)  word address.
- req_be  in  DATA_W/8  byte enables for writes; ignored on reads.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read data valid, one-cycle pulse per accepted read; no backpressure.
- rsp_data  out  DATA_W  read data.
- init_done  out  1  high once clearing has completed.

## Operation
- Bank decode: INTERLEAVE=0 → bank = req_addr[MSBs], index = req_addr[BANK_ADDR_W-1:0]; INTERLEAVE=1 → bank = req_addr[log2(NUM_BANKS)-1:0], index = remaining upper bits. Exactly one bank enabled per accepted request; none otherwise.
- States: CLEAR, RUN.
- CLEAR: entered on reset. A counter walks index 0..2^BANK_ADDR_W-1, writing all-zero to that index in every bank simultaneously, one index per cycle. req_ready=0, init_done=0. After the last index, go to RUN.
- RUN: req_ready=1 every cycle; init_done=1.
- Write: byte lanes with req_be[i]=1 are updated; other lanes keep their old value. req_be=0 is a legal no-op. Writes produce no response.
- Read: returns the full word of the addressed bank/index.
- Read of an address written in the previous cycle returns the new data; single port, so each cycle carries at most one request.
- rsp_data holds its last value when rsp_valid=0.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, init_done=0, state=CLEAR, clear counter=0.
- CLEAR lasts exactly 2^BANK_ADDR_W cycles after the first cycle with reset low. With the defaults, the first accept is possible on cycle 1024 after reset deasserts.
- Read latency: accepted at edge N → rsp_valid=1 with data in cycle N+1. Back-to-back reads give one response per cycle.
- Write takes effect at the accepting edge.
- Reset asserted in any state, including with a read in flight: the in-flight response is dropped (rsp_valid=0 the next cycle), state returns to CLEAR and the full clear restarts from index 0. Memory contents are all zero once CLEAR completes.
- Requests presented while req_ready=0 are ignored and must not modify memory.

## Structure
- Package dmem_pkg: state enum {CLEAR, RUN}; localparam helpers for bank-select width, total address width and byte-lane count.
- Sub-module dmem_bank: one bank, synchronous write with byte enables and registered read, parameterised on DATA_W and BANK_ADDR_W. Instantiated NUM_BANKS times via generate. Top level owns decode, the CLEAR FSM/counter, response valid and the read mux, which uses the registered bank select.

## Test plan
- Reset release (defaults) → req_ready=0 for exactly 1024 cycles, then 1; read of addr 0x1FFF returns 0x00000000.
- Write 0xDEADBEEF to addr 0x0405 with be=4'b1111, then write 0x000000AA with be=4'b0001 → read returns 0xDEADBEAA one cycle after accept.
- INTERLEAVE=0: write addrs 0x0000 and 0x0400 with distinct data → bank 0 and bank 1 hold the values at index 0. INTERLEAVE=1: addrs 0x0000 and 0x0001 → bank 0 and bank 1 at index 0. Read-back matches.
- Back-to-back reads of 8 consecutive addresses → 8 consecutive rsp_valid cycles with correct data in order.
- Write then immediate read of the same address → new data at N+1. Write with req_be=0 → contents unchanged.
- Reset asserted the cycle after a read is accepted → rsp_valid stays 0. After the new 1024-cycle clear, previously written addresses read 0.
